// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_LSU   = 1'b1
   } owner_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
   } mem_cmd_t;

   // Fetch is always a full-word read.
   function automatic mem_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
      mem_cmd_t c;
      c.we    = 1'b0;
      c.addr  = addr;
      c.wdata = '0;
      c.be    = {BE_W{1'b1}};
      return c;
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of LSU wins while fetch is waiting; flags when fetch must win.
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit_c
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != CNT_W'(LIMIT))) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_at_limit_c = (r_cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction at a time,
// LSU-first with a starvation guard for fetch.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter bit          RESET_OWNER  = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic              fetch_gnt_o,
   output logic              fetch_rvalid_o,
   output logic [DATA_W-1:0] fetch_rdata_o,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_wdata_i,
   input  logic [BE_W-1:0]   lsu_be_i,
   output logic              lsu_gnt_o,
   output logic              lsu_rvalid_o,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [BE_W-1:0]   mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              err_o
);

   arb_state_e r_state;
   owner_e     r_owner;
   mem_cmd_t   r_cmd;
   logic       r_mem_req;
   logic       r_busy;
   logic       r_err;

   logic w_any_req, w_starved, w_sel_lsu, w_arb;
   logic w_cnt_inc, w_cnt_clr, w_err_set;
   logic w_fire_gnt, w_fire_rsp;
   mem_cmd_t w_lsu_cmd;

   assign w_any_req = fetch_req_i | lsu_req_i;
   assign w_sel_lsu = lsu_req_i & ~(fetch_req_i & w_starved);
   assign w_arb     = (r_state == IDLE) & w_any_req;
   assign w_cnt_inc = w_arb & w_sel_lsu & fetch_req_i;
   assign w_cnt_clr = ~fetch_req_i | (w_arb & ~w_sel_lsu);
   assign w_err_set = (mem_rvalid_i & (r_state != RESP)) | (mem_gnt_i & ~r_mem_req);

   assign w_lsu_cmd = '{we: lsu_we_i, addr: lsu_addr_i, wdata: lsu_wdata_i, be: lsu_be_i};

   arb_starve_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk_i       (clk_i),
      .rst_ni      (rst_i),
      .i_inc       (w_cnt_inc),
      .i_clr       (w_cnt_clr),
      .o_at_limit_c(w_starved)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state   <= IDLE;
         r_owner   <= owner_e'(RESET_OWNER);
         r_cmd     <= '0;
         r_mem_req <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_err_set) r_err <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner   <= w_sel_lsu ? OWN_LSU : OWN_FETCH;
                  r_cmd     <= w_sel_lsu ? w_lsu_cmd : fetch_cmd(fetch_addr_i);
                  r_mem_req <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt_i) begin
                  r_mem_req <= 1'b0;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               if (mem_rvalid_i) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   // Handshake pulses are combinational from memory; reset suppresses them.
   assign w_fire_gnt = rst_i & mem_gnt_i & r_mem_req;
   assign w_fire_rsp = rst_i & mem_rvalid_i & (r_state == RESP);

   assign fetch_gnt_o    = w_fire_gnt & (r_owner == OWN_FETCH);
   assign lsu_gnt_o      = w_fire_gnt & (r_owner == OWN_LSU);
   assign fetch_rvalid_o = w_fire_rsp & (r_owner == OWN_FETCH);
   assign lsu_rvalid_o   = w_fire_rsp & (r_owner == OWN_LSU);
   assign fetch_rdata_o  = fetch_rvalid_o ? mem_rdata_i : '0;
   assign lsu_rdata_o    = lsu_rvalid_o ? mem_rdata_i : '0;

   assign mem_req_o   = r_mem_req;
   assign mem_we_o    = r_cmd.we;
   assign mem_addr_o  = r_cmd.addr;
   assign mem_wdata_o = r_cmd.wdata;
   assign mem_be_o    = r_cmd.be;
   assign busy_o      = r_busy;
   assign err_o       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// starvation and dropped-request sequences.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        fetch_req_i;
   logic [31:0] fetch_addr_i;
   logic        fetch_gnt_o, fetch_rvalid_o;
   logic [31:0] fetch_rdata_o;
   logic        lsu_req_i, lsu_we_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic [3:0]  lsu_be_i;
   logic        lsu_gnt_o, lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o, err_o;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.STARVE_LIMIT(4), .RESET_OWNER(1'b0)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
      .fetch_gnt_o(fetch_gnt_o), .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_be_i(lsu_be_i),
      .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct packed {
      logic        fgnt, frv;
      logic [31:0] frd;
      logic        lgnt, lrv;
      logic [31:0] lrd;
      logic        mreq, mwe;
      logic [31:0] maddr, mwd;
      logic [3:0]  mbe;
      logic        busy, err;
   } obs_t;

   typedef struct {
      logic        rst, freq, lreq, lwe, mgnt, mrv;
      logic [31:0] faddr, laddr, lwd, mrd;
      logic [3:0]  lbe;
      obs_t        exp;
   } vec_t;

   vec_t tbl[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   logic [31:0] g_faddr, g_laddr, g_lwd;
   logic [3:0]  g_lbe;
   logic        g_lwe;

   // cmd: 0 = mem_* all zero, 1 = current fetch command, 2 = current LSU command.
   function automatic void row(input logic r, f, l, g, v, input logic [31:0] d,
                               input logic fg, fv, lg, lv, mq, input int cmd,
                               input logic bz, er);
      vec_t x;
      obs_t e;
      x.rst = r; x.freq = f; x.lreq = l; x.mgnt = g; x.mrv = v; x.mrd = d;
      x.faddr = g_faddr; x.laddr = g_laddr; x.lwd = g_lwd; x.lbe = g_lbe; x.lwe = g_lwe;
      e = '0;
      e.fgnt = fg; e.frv = fv; e.frd = fv ? d : 32'h0;
      e.lgnt = lg; e.lrv = lv; e.lrd = lv ? d : 32'h0;
      e.mreq = mq; e.busy = bz; e.err = er;
      if (cmd == 1) begin
         e.maddr = g_faddr; e.mbe = 4'hF;
      end else if (cmd == 2) begin
         e.mwe = g_lwe; e.maddr = g_laddr; e.mwd = g_lwd; e.mbe = g_lbe;
      end
      x.exp = e;
      tbl.push_back(x);
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.fgnt = fetch_gnt_o; o.frv = fetch_rvalid_o; o.frd = fetch_rdata_o;
      o.lgnt = lsu_gnt_o;   o.lrv = lsu_rvalid_o;   o.lrd = lsu_rdata_o;
      o.mreq = mem_req_o;   o.mwe = mem_we_o;       o.maddr = mem_addr_o;
      o.mwd = mem_wdata_o;  o.mbe = mem_be_o;       o.busy = busy_o; o.err = err_o;
      return o;
   endfunction

   task automatic cmp(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t x);
      rst_i = x.rst; fetch_req_i = x.freq; fetch_addr_i = x.faddr;
      lsu_req_i = x.lreq; lsu_we_i = x.lwe; lsu_addr_i = x.laddr;
      lsu_wdata_i = x.lwd; lsu_be_i = x.lbe;
      mem_gnt_i = x.mgnt; mem_rvalid_i = x.mrv; mem_rdata_i = x.mrd;
   endtask

   task automatic idle_inputs();
      fetch_req_i = 1'b0; fetch_addr_i = '0; lsu_req_i = 1'b0; lsu_we_i = 1'b0;
      lsu_addr_i = '0; lsu_wdata_i = '0; lsu_be_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
   endtask

   initial begin
      int   nfg, nfv, nl;
      logic [31:0] rd;
      logic el;

      rst_i = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk_i);
      #1;

      g_faddr = RESET_PC; g_laddr = 32'h8000_1000; g_lwd = 32'hDEAD_BEEF;
      g_lbe = 4'b0011; g_lwe = 1'b1;
      //    r f l g v data          fg fv lg lv mq cmd bz er
      // fetch only, zero-wait memory
      row(1,1,0,0,0,32'h0,          0,0,0,0,0, 0, 0,0);
      row(1,1,0,1,0,32'h0,          1,0,0,0,1, 1, 1,0);
      row(1,0,0,0,1,32'h0000_0013,  0,1,0,0,0, 1, 1,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 1, 0,0);
      // LSU write, grant after three wait cycles
      row(1,0,1,0,0,32'h0,          0,0,0,0,0, 1, 0,0);
      row(1,0,1,0,0,32'h0,          0,0,0,0,1, 2, 1,0);
      row(1,0,1,0,0,32'h0,          0,0,0,0,1, 2, 1,0);
      row(1,0,1,0,0,32'h0,          0,0,0,0,1, 2, 1,0);
      row(1,0,1,1,0,32'h0,          0,0,1,0,1, 2, 1,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 2, 1,0);
      row(1,0,0,0,1,32'h1234_5678,  0,0,0,1,0, 2, 1,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 2, 0,0);
      // stray response in IDLE; err sticks until reset
      row(1,0,0,0,1,32'hAAAA_5555,  0,0,0,0,0, 2, 0,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 2, 0,1);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 2, 0,1);
      row(0,0,0,0,0,32'h0,          0,0,0,0,0, 2, 0,1);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,0);
      // reset during RESP coinciding with rvalid, then a late rvalid
      g_faddr = 32'h8000_0004;
      row(1,1,0,0,0,32'h0,          0,0,0,0,0, 0, 0,0);
      row(1,1,0,1,0,32'h0,          1,0,0,0,1, 1, 1,0);
      row(0,0,0,0,1,32'hCAFE_F00D,  0,0,0,0,0, 1, 1,0);
      row(1,0,0,0,1,32'hCAFE_F00D,  0,0,0,0,0, 0, 0,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,1);
      // grant with no request outstanding
      row(0,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,1);
      row(1,0,0,1,0,32'h0,          0,0,0,0,0, 0, 0,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,1);
      // reset coinciding with grant suppresses the pulse
      row(0,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,1);
      row(1,1,0,0,0,32'h0,          0,0,0,0,0, 0, 0,0);
      row(0,1,0,1,0,32'h0,          0,0,0,0,1, 1, 1,0);
      row(1,0,0,0,0,32'h0,          0,0,0,0,0, 0, 0,0);

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk_i);
         cmp($sformatf("vec%0d", i), 160'(observe()), 160'(tbl[i].exp));
         @(posedge clk_i); #1;
      end

      // Starvation guard: both held, zero-wait memory, transaction every 3 cycles.
      do_reset();
      fetch_req_i = 1'b1; fetch_addr_i = RESET_PC;
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_2000; lsu_be_i = 4'hF;
      for (int t = 0; t < 30; t++) begin
         mem_gnt_i    = ((t % 3) == 1);
         mem_rvalid_i = ((t % 3) == 2);
         mem_rdata_i  = 32'h100 + 32'(t);
         el = (((t / 3) % 5) != 4);
         @(negedge clk_i);
         if ((t % 3) == 1)
            cmp($sformatf("starve_gnt%0d", t / 3), 160'({lsu_gnt_o, fetch_gnt_o}),
                160'({el, ~el}));
         if ((t % 3) == 2)
            cmp($sformatf("starve_rsp%0d", t / 3),
                160'({lsu_rvalid_o, fetch_rvalid_o, lsu_rdata_o, fetch_rdata_o}),
                160'({el, ~el, el ? mem_rdata_i : 32'h0, el ? 32'h0 : mem_rdata_i}));
         @(posedge clk_i); #1;
      end

      // Fetch drops its request while waiting for grant.
      do_reset();
      nfg = 0; nfv = 0; nl = 0; rd = '0;
      fetch_addr_i = 32'h8000_0008;
      for (int t = 0; t < 6; t++) begin
         fetch_req_i  = (t == 0);
         mem_gnt_i    = (t == 2);
         mem_rvalid_i = (t == 3);
         mem_rdata_i  = 32'h0000_0013;
         @(negedge clk_i);
         if (t == 1)
            cmp("drop_hold", 160'({mem_req_o, mem_addr_o}), 160'({1'b1, 32'h8000_0008}));
         nfg += int'(fetch_gnt_o);
         nfv += int'(fetch_rvalid_o);
         nl  += int'(lsu_gnt_o) + int'(lsu_rvalid_o);
         if (fetch_rvalid_o) rd = fetch_rdata_o;
         @(posedge clk_i); #1;
      end
      cmp("drop_gnt_count", 160'(nfg), 160'(1));
      cmp("drop_rvalid_count", 160'(nfv), 160'(1));
      cmp("drop_rdata", 160'(rd), 160'(32'h0000_0013));
      cmp("drop_lsu_quiet", 160'(nl), 160'(0));
      cmp("drop_end_state", 160'({busy_o, err_o}), 160'(2'b00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
